// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and helpers for the iterative arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    typedef enum logic [0:0] {
        RESTING     = 1'b0,
        MULTIPLYING = 1'b1
    } arith_state_t;

    // Iteration counter width; never below one bit so WIDTH=2 still has a counter.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : arith_pkg

`default_nettype wire

// File: rtl/mul_add.sv
// ============================================================================
// Module      : mul_add
// Description : Sequential shift-and-add dividend = quotient*divisor+remainder,
//               fixed latency of WIDTH cycles, error when remainder is invalid
//               or the result does not fit in WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_add
    import arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] remainder,
    input  logic             data_in_valid,
    output logic [WIDTH-1:0] dividend,
    output logic             data_out_valid,
    output logic             error,
    output logic             busy
);

    localparam int          c_cw   = count_width(WIDTH);
    localparam int          c_aw   = 2 * WIDTH + 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    arith_state_t       r_state;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_b;
    logic [c_aw-1:0]    r_acc;
    logic               r_bad;
    logic [c_cw-1:0]    r_count;

    logic [c_aw-1:0]    w_acc_next;
    logic               w_overflow;

    // Accumulator after this cycle's conditional add; the final cycle's value
    // feeds the result directly so completion lands on edge WIDTH.
    always_comb begin
        w_acc_next = r_acc + (r_a[0] ? {1'b0, r_b} : {c_aw{1'b0}});
        w_overflow = |w_acc_next[c_aw-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RESTING;
            r_a            <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_bad          <= 1'b0;
            r_count        <= '0;
            dividend       <= '0;
            data_out_valid <= 1'b0;
            error          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                RESTING: begin
                    data_out_valid <= 1'b0;
                    if (data_in_valid) begin
                        r_a     <= quotient;
                        r_b     <= {{WIDTH{1'b0}}, divisor};
                        r_acc   <= {{(WIDTH + 1){1'b0}}, remainder};
                        r_bad   <= (remainder >= divisor);
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= MULTIPLYING;
                    end
                end
                MULTIPLYING: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b << 1;
                    r_count <= r_count + c_cw'(1);
                    if (r_count == c_last) begin
                        if (r_bad || w_overflow) begin
                            dividend <= '0;
                            error    <= 1'b1;
                        end else begin
                            dividend <= w_acc_next[WIDTH-1:0];
                            error    <= 1'b0;
                        end
                        data_out_valid <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= RESTING;
                    end
                end
                default: begin
                    r_state <= RESTING;
                end
            endcase
        end
    end

endmodule : mul_add

`default_nettype wire

// File: tb/tb_mul_add.sv
// ============================================================================
// Module      : tb_mul_add
// Description : Self-checking bench for mul_add (WIDTH=32): directed vectors,
//               handshake/reset sequences and randomized round trips.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_add;

    localparam int c_w = 32;

    logic           clk;
    logic           rst;
    logic [c_w-1:0] quotient;
    logic [c_w-1:0] divisor;
    logic [c_w-1:0] remainder;
    logic           data_in_valid;
    logic [c_w-1:0] dividend;
    logic           data_out_valid;
    logic           error;
    logic           busy;

    int checks;
    int errors;

    mul_add #(.WIDTH(c_w)) dut (
        .clk            (clk),
        .rst            (rst),
        .quotient       (quotient),
        .divisor        (divisor),
        .remainder      (remainder),
        .data_in_valid  (data_in_valid),
        .dividend       (dividend),
        .data_out_valid (data_out_valid),
        .error          (error),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] d;
        logic [31:0] r;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned q*d+r in wide arithmetic, rejected if r>=d or too big.
    task automatic model(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r,
                         output logic [31:0] res, output logic err);
        logic [64:0] sum;
        sum = {33'd0, q} * {33'd0, d} + {33'd0, r};
        err = (r >= d) || (sum >= 65'h1_0000_0000);
        res = err ? 32'd0 : sum[31:0];
    endtask

    task automatic accept_now(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        quotient      = q;
        divisor       = d;
        remainder     = r;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1 data_in_valid = 1'b0;
    endtask

    task automatic start(input logic [31:0] q, input logic [31:0] d, input logic [31:0] r);
        @(negedge clk);
        accept_now(q, d, r);
    endtask

    // Returns edges from the accept edge until data_out_valid (0 on timeout)
    // and whether busy was ever low before completion or high at completion.
    task automatic wait_done(output int lat, output logic busy_bad);
        lat      = 0;
        busy_bad = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (data_out_valid) begin
                lat = i;
                if (busy) busy_bad = 1'b1;
                break;
            end
            if (!busy) busy_bad = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] q, input logic [31:0] d,
                          input logic [31:0] r, input logic [31:0] er, input logic ee,
                          input logic full);
        int   lat;
        logic bb;
        start(q, d, r);
        wait_done(lat, bb);
        chk({tag, "_dividend"}, dividend, er);
        chk({tag, "_error"}, error, ee);
        if (full) begin
            chk({tag, "_latency"}, lat, c_w);
            chk({tag, "_busy"}, bb, 0);
            @(posedge clk);
            #1 chk({tag, "_pulse_width"}, data_out_valid, 0);
        end else if (lat == 0) begin
            chk({tag, "_timeout"}, 1, 0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int          lat;
        logic        bb;
        logic [31:0] er;
        logic        ee;
        logic [31:0] q, d, r, dvd;
        int          seen;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        quotient      = '0;
        divisor       = '0;
        remainder     = '0;

        vecs[0] = '{32'd7,          32'd5,          32'd3,          32'd38,         1'b0};
        vecs[1] = '{32'd9,          32'd0,          32'd0,          32'd0,          1'b1};
        vecs[2] = '{32'd4,          32'd6,          32'd6,          32'd0,          1'b1};
        vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[4] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          32'd0,          1'b1};
        vecs[5] = '{32'h7FFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{32'd0,          32'd5,          32'd4,          32'd4,          1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd0,          1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dividend", dividend, 0);
        chk("reset_error", error, 0);
        chk("reset_valid", data_out_valid, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r,
                   vecs[i].exp_res, vecs[i].exp_err, 1'b1);

        // Request during an operation is dropped.
        start(32'd7, 32'd5, 32'd3);
        repeat (9) @(posedge clk);
        #1 accept_now(32'd100, 32'd100, 32'd1);
        wait_done(lat, bb);
        lat = (lat == 0) ? 0 : lat + 10;
        chk("ignore_latency", lat, c_w);
        chk("ignore_dividend", dividend, 38);
        chk("ignore_error", error, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (data_out_valid || busy) seen++;
        end
        chk("ignore_no_second", seen, 0);

        // Back-to-back: new request in the completion cycle.
        start(32'd3, 32'd11, 32'd2);
        wait_done(lat, bb);
        chk("b2b_first_dividend", dividend, 35);
        accept_now(32'd1000, 32'd1000, 32'd999);
        wait_done(lat, bb);
        chk("b2b_second_latency", lat, c_w);
        chk("b2b_second_dividend", dividend, 1000999);
        chk("b2b_second_error", error, 0);

        // Reset at cycle 12 of an operation abandons it.
        start(32'd123, 32'd456, 32'd7);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_dividend", dividend, 0);
        chk("midrst_error", error, 0);
        chk("midrst_valid", data_out_valid, 0);
        chk("midrst_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (data_out_valid) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        run_op("after_rst", 32'd123, 32'd456, 32'd7, 32'd56095, 1'b0, 1'b1);

        // Random MAC operands, including invalid remainders and overflow.
        for (int i = 0; i < 150; i++) begin
            q = $urandom >> $urandom_range(0, 31);
            d = $urandom >> $urandom_range(0, 31);
            r = $urandom >> $urandom_range(0, 31);
            model(q, d, r, er, ee);
            run_op("rand_mac", q, d, r, er, ee, (i < 5) ? 1'b1 : 1'b0);
        end

        // Round trip through an ideal divider.
        for (int i = 0; i < 1000; i++) begin
            dvd = $urandom;
            d   = $urandom >> $urandom_range(0, 31);
            if (d == 0) d = 32'd1;
            q = dvd / d;
            r = dvd % d;
            run_op("roundtrip", q, d, r, dvd, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_add

`default_nettype wire

// File: doc/mul_add.md
# mul_add

Sequential shift-and-add multiply-accumulate unit computing `dividend = quotient * divisor + remainder`. It is the inverse of the iterative divider and shares the same valid/busy/error handshake. It is used to reconstruct operands and to self-check divider results in the arithmetic datapath. Latency is fixed at WIDTH cycles, independent of operand values.

## Interface
- `WIDTH`, default 32: operand and result width in bits; legal values are 2 or greater.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `quotient` input WIDTH: multiplier operand; sampled only on accept.
- `divisor` input WIDTH: multiplicand operand; sampled only on accept.
- `remainder` input WIDTH: addend; sampled only on accept.
- `data_in_valid` input 1: request strobe; takes effect only in RESTING.
- `dividend` output WIDTH: result; holds until the next completion.
- `data_out_valid` output 1: one-cycle completion pulse.
- `error` output 1: qualified by `data_out_valid`; holds with `dividend`.
- `busy` output 1: high while an operation is in flight.

## Operation
- States: RESTING and MULTIPLYING.
- **Accept** (RESTING, `data_in_valid` = 1):
  - Latch `a` = `quotient` and `b` = `divisor` (b zero-extended to 2·WIDTH).
  - Initialise the accumulator to `remainder`. The accumulator is 2·WIDTH+1 bits wide.
  - Latch `bad` = (`remainder` >= `divisor`); this covers `divisor` == 0.
  - Set count = 0, `busy` = 1, and go to MULTIPLYING.
- **RESTING, every cycle:** `data_out_valid` is driven to 0.
- **MULTIPLYING, each cycle:**
  - If a[0] = 1, add b to the accumulator.
  - Shift a right by 1 and b left by 1, then increment count.
- **Last iteration** (count = WIDTH-1):
  - Next-accumulator value = this cycle's accumulator plus the conditional add of b.
  - Overflow = next-accumulator bits [2·WIDTH:WIDTH] are nonzero.
  - If `bad` or overflow: `dividend` = 0 and `error` = 1.
  - Otherwise: `dividend` = next-accumulator [WIDTH-1:0] and `error` = 0.
  - Set `data_out_valid` = 1 and `busy` = 0, and return to RESTING.
- **`data_in_valid` while MULTIPLYING:** ignored; there is no queueing, and inputs may change freely.
- **Arithmetic:** all unsigned. The accumulator cannot wrap, because the maximum value (2^W−1)²+(2^W−1) fits in 2·WIDTH bits. The extra bit is margin only.

## Timing
- **Reset values:** `dividend` = 0, `error` = 0, `data_out_valid` = 0, `busy` = 0, state RESTING. All internal registers are cleared.
- **Accept edge (edge 0):** `busy` rises after edge 0.
- **Completion:** the result, `error`, and `data_out_valid` are visible after edge WIDTH, with `busy` low in the same cycle.
  - `data_out_valid` is exactly one cycle wide.
- **Throughput:** one operation per WIDTH+1 cycles.
  - `data_in_valid` asserted in the cycle where `data_out_valid` = 1 is accepted, because the state is already RESTING.
- **Reset mid-operation:** the operation is abandoned. No `data_out_valid` follows, and all outputs return to their reset values after the edge.
- **Outputs:** all registered; there are no combinational paths from input to output.

## Structure
- Shared package `arith_pkg`:
  - Holds the state enum (RESTING, MULTIPLYING), used by this block and by the divider.
  - Holds a function that returns the counter width as $clog2(WIDTH).
- No sub-module is natural. The block is a single clocked process with a small combinational next-accumulator term; a parallel multiplier is explicitly not used.

## Test plan
- **Basic result and latency:** WIDTH=32, q=7, d=5, r=3 → `dividend` = 38, `error` = 0, `data_out_valid` exactly 32 cycles after the accept edge, `busy` high for cycles 1..31.
- **Invalid remainder:**
  - q=9, d=0, r=0 → `error` = 1, `dividend` = 0.
  - q=4, d=6, r=6 → `error` = 1, `dividend` = 0.
- **Overflow boundary:**
  - q=0xFFFFFFFF, d=1, r=0 → 0xFFFFFFFF, `error` = 0.
  - q=0x10000, d=0x10000, r=0 → `error` = 1.
  - q=0x7FFFFFFF, d=2, r=1 → 0xFFFFFFFF, `error` = 0.
- **Handshake:**
  - `data_in_valid` pulsed at cycle 10 of a busy operation → ignored, and the first result is unchanged.
  - A new request in the `data_out_valid` cycle → accepted, with a second result 32 cycles later.
- **Reset mid-operation:** `rst` at cycle 12 of an operation → all outputs 0 next cycle, no `data_out_valid`, and a following request completes normally.
- **Round trip:** 1000 random (dividend, nonzero divisor) pairs run through the divider, then its quotient/divisor/remainder through this block → the original dividend is recovered with `error` = 0 every time.
